// File: rtl/lc4_divider_iter.sv
// Iterative 16-bit unsigned restoring divider for the LC4 DIV/MOD instructions.
// One quotient bit per clock, 16 clocks per operation, back-to-back issue from DONE.
module lc4_divider_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_dividend,
  input  logic [15:0] i_divisor,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_valid,
  output logic [15:0] o_quotient,
  output logic [15:0] o_remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] dsr_q, dsr_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] rmd_q, rmd_d;

  logic        accept;
  logic        last_step;
  logic [16:0] rem_shift;
  logic [16:0] diff;
  logic        qbit;
  logic [15:0] rem_step;
  logic [15:0] dvd_step;

  assign accept    = i_start && o_ready;
  assign last_step = (state_q == RUN) && (cnt_q == 4'd15);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (cnt_q == 4'd15) state_d = DONE;
      DONE:    state_d = i_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_ready = (state_q != RUN);
    o_busy  = (state_q == RUN);
    o_valid = (state_q == DONE);
  end

  // The shifted partial remainder can reach 17 bits; the compare and subtract
  // are done at that width so the borrow bit alone decides the quotient bit.
  always_comb begin
    rem_shift = {rem_q, dvd_q[15]};
    diff      = rem_shift - {1'b0, dsr_q};
    qbit      = ~diff[16];
    rem_step  = qbit ? diff[15:0] : rem_shift[15:0];
    dvd_step  = {dvd_q[14:0], qbit};
  end

  // Quotient bits shift into the dividend register as dividend bits shift out.
  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    rem_d = rem_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    if (accept) begin
      cnt_d = 4'd0;
      dvd_d = i_dividend;
      dsr_d = i_divisor;
      rem_d = 16'd0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 4'd1;
      dvd_d = dvd_step;
      rem_d = rem_step;
      if (last_step) begin
        // Division by zero reports 0/0 rather than the raw all-ones quotient.
        quo_d = (dsr_q == 16'd0) ? 16'd0 : dvd_step;
        rmd_d = (dsr_q == 16'd0) ? 16'd0 : rem_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
      dvd_q <= 16'd0;
      dsr_q <= 16'd0;
      rem_q <= 16'd0;
      quo_q <= 16'd0;
      rmd_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
    end
  end

  assign o_quotient  = quo_q;
  assign o_remainder = rmd_q;

endmodule

// File: tb/tb_lc4_divider_iter.sv
// Scoreboard bench for lc4_divider_iter: directed corner cases plus random
// operand pairs checked against plain / and % with divide-by-zero giving 0/0.
module tb_lc4_divider_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_ready;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  lc4_divider_iter dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    int          due;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  logic [15:0] last_q = 16'd0;
  logic [15:0] last_r = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  // Reference model: plain arithmetic with the DIV/MOD zero-divisor rule
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int due);
    exp_t e;
    e.a = a;
    e.b = b;
    e.due = due;
    if (b == 16'd0) begin
      e.q = 16'd0;
      e.r = 16'd0;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on each o_valid and checks timing and data
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready_vs_busy", int'(o_ready), int'(!o_busy));
      if (o_valid) begin
        check("valid_not_busy", int'(o_busy), 0);
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid: got o_valid=1 expected 0 q=0x%0h r=0x%0h (cycle %0d)",
                   o_quotient, o_remainder, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", int'(o_quotient), int'(e.q));
          check("remainder", int'(o_remainder), int'(e.r));
          check("latency", cyc, e.due);
          $display("op 0x%04h / 0x%04h -> q=0x%04h r=0x%04h (exp q=0x%04h r=0x%04h)",
                   e.a, e.b, o_quotient, o_remainder, e.q, e.r);
        end
        last_q = o_quotient;
        last_r = o_remainder;
      end else begin
        if (sb.size() > 0 && cyc > sb[0].due) begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          $display("FAIL missing_valid: got no o_valid by cycle %0d expected at cycle %0d",
                   cyc, e.due);
        end
        if (rst) begin
          last_q = 16'd0;
          last_r = 16'd0;
        end else begin
          check("hold_quotient", int'(o_quotient), int'(last_q));
          check("hold_remainder", int'(o_remainder), int'(last_r));
        end
      end
    end
  end

  // Caller guarantees o_ready=1 at this point (1ns after a rising edge)
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
    check("ready_at_issue", int'(o_ready), 1);
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    @(posedge clk);
    #1;
    check("busy_after_accept", int'(o_busy), 1);
    if (push) sb.push_back(model(a, b, cyc + 16));
    i_start    = 1'b0;
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
  endtask

  // Waits (bounded) for o_ready; optionally jiggles inputs and i_start during RUN
  task automatic wait_ready(input bit noise);
    int n = 0;
    while (!o_ready && n < 40) begin
      if (noise) begin
        i_start    = 1'($urandom_range(0, 1));
        i_dividend = 16'($urandom);
        i_divisor  = 16'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    i_start = 1'b0;
    if (!o_ready) check("ready_timeout", int'(o_ready), 1);
  endtask

  task automatic idle_cycles(input int n);
    i_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] rand_divisor();
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return 16'd1;
      2:       return 16'($urandom_range(1, 15));
      3:       return 16'hFFFF;
      4:       return 16'($urandom_range(16'h8000, 16'hFFFF));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_dividend();
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return 16'hFFFF;
      2:       return 16'($urandom_range(0, 31));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst        = 1'b1;
    i_start    = 1'b0;
    i_dividend = 16'd0;
    i_divisor  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", int'(o_ready), 1);
    check("reset_busy", int'(o_busy), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_quotient", int'(o_quotient), 0);
    check("reset_remainder", int'(o_remainder), 0);
    mon_en = 1'b1;
    idle_cycles(2);

    // 100 / 7, exact latency checked by the monitor
    issue(16'd100, 16'd7, 1'b1);
    wait_ready(1'b0);
    idle_cycles(2);

    // 0xFFFF / 1, then 3 / 10 issued in the DONE cycle
    issue(16'hFFFF, 16'h0001, 1'b1);
    wait_ready(1'b0);
    check("done_valid_b2b", int'(o_valid), 1);
    issue(16'h0003, 16'h000A, 1'b1);
    wait_ready(1'b0);
    idle_cycles(1);

    // Divide by zero
    issue(16'h0005, 16'h0000, 1'b1);
    wait_ready(1'b0);
    idle_cycles(1);

    // Input changes and i_start pulses during RUN must be ignored
    issue(16'h8000, 16'h0003, 1'b1);
    wait_ready(1'b1);
    idle_cycles(2);

    // Reset at iteration 8 aborts with no result, then the same request completes
    issue(16'h1234, 16'h0011, 1'b0);
    idle_cycles(7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", int'(o_ready), 1);
    check("abort_busy", int'(o_busy), 0);
    check("abort_valid", int'(o_valid), 0);
    check("abort_quotient", int'(o_quotient), 0);
    check("abort_remainder", int'(o_remainder), 0);
    idle_cycles(20);
    issue(16'h1234, 16'h0011, 1'b1);
    wait_ready(1'b0);
    idle_cycles(1);

    // Randomized operands, mixing back-to-back issue, idle gaps and RUN noise
    for (int k = 0; k < 2500; k++) begin
      issue(rand_dividend(), rand_divisor(), 1'b1);
      wait_ready($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    idle_cycles(2);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
